// File: rtl/adder_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim_checker
// Purpose  : Self-test driver for a 3-bit full adder. Steps all eight input
//            vectors, checks sum/carry and latches pass/fail results.
// Revision : 1.0 - initial release
// ============================================================================
module adder_stim_checker #(
    parameter int STEP_CYCLES   = 50_000_000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] stim,
    input  logic       sum_in,
    input  logic       carry_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vec,
    output logic       fail_seen
);

    localparam int              c_CW     = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE_CYCLES);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(STEP_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_start_q;
    logic [2:0]      r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [3:0]      r_err_count;
    logic [2:0]      r_fail_vec;
    logic            r_fail_seen;

    logic       w_start_edge;
    logic       w_exp_sum;
    logic       w_exp_carry;
    logic       w_mismatch;
    logic       w_sample;
    logic       w_step;
    logic       w_hit;
    logic [3:0] w_err_next;

    assign w_start_edge = start & ~r_start_q;
    assign w_exp_sum    = ^r_stim;
    assign w_exp_carry  = (r_stim[2] & r_stim[1]) | (r_stim[2] & r_stim[0]) | (r_stim[1] & r_stim[0]);
    assign w_mismatch   = (sum_in != w_exp_sum) | (carry_in != w_exp_carry);
    assign w_sample     = (r_state == c_RUN) && (r_cnt == c_SETTLE);
    assign w_step       = (r_state == c_RUN) && (r_cnt == c_LAST);
    assign w_hit        = w_sample & w_mismatch;
    // Count including this edge's comparison so a coincident final step sees it.
    assign w_err_next   = r_err_count + {3'b000, w_hit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_start_q   <= 1'b0;
            r_stim      <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 4'd0;
            r_fail_vec  <= 3'd0;
            r_fail_seen <= 1'b0;
        end else begin
            r_start_q <= start;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_start_edge) begin
                        r_state     <= c_RUN;
                        r_cnt       <= '0;
                        r_stim      <= 3'd0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= 4'd0;
                        r_fail_vec  <= 3'd0;
                        r_fail_seen <= 1'b0;
                    end
                end
                c_RUN: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_hit) begin
                        r_err_count <= w_err_next;
                        if (!r_fail_seen) begin
                            r_fail_vec  <= r_stim;
                            r_fail_seen <= 1'b1;
                        end
                    end
                    if (w_step) begin
                        r_cnt <= '0;
                        if (r_stim != 3'd7) begin
                            r_stim <= r_stim + 3'd1;
                        end else begin
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_stim  <= 3'd0;
                            r_pass  <= (w_err_next == 4'd0);
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stim      = r_stim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;
    assign fail_seen = r_fail_seen;

endmodule
`default_nettype wire

// File: tb/tb_adder_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_stim_checker
// Purpose  : Directed bench with a fault-injectable full-adder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_stim_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [2:0] stim, stim2;
    logic       sum_in, carry_in, sum_in2, carry_in2;
    logic       busy, done, pass, fail_seen;
    logic       busy2, done2, pass2, fail_seen2;
    logic [3:0] err_count, err_count2;
    logic [2:0] fail_vec, fail_vec2;
    int         fault = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Adder models: 0 good, 1 carry stuck at 0, 2 sum inverted on vector 5.
    always_comb begin
        sum_in   = stim[2] ^ stim[1] ^ stim[0];
        carry_in = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
        if (fault == 1) carry_in = 1'b0;
        if (fault == 2 && stim == 3'd5) sum_in = ~sum_in;
    end

    // Second adder: carry wrong only on vector 7.
    always_comb begin
        sum_in2   = stim2[2] ^ stim2[1] ^ stim2[0];
        carry_in2 = (stim2[2] & stim2[1]) | (stim2[2] & stim2[0]) | (stim2[1] & stim2[0]);
        if (stim2 == 3'd7) carry_in2 = ~carry_in2;
    end

    adder_stim_checker #(.STEP_CYCLES(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim),
        .sum_in(sum_in), .carry_in(carry_in), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_vec(fail_vec), .fail_seen(fail_seen)
    );

    adder_stim_checker #(.STEP_CYCLES(4), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stim(stim2),
        .sum_in(sum_in2), .carry_in(carry_in2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err_count2), .fail_vec(fail_vec2), .fail_seen(fail_seen2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_stim", 32'(stim), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_fvec", 32'(fail_vec), 0);
        chk("rst_fseen", 32'(fail_seen), 0);

        // Good adder: full run
        fault = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int v = 0; v < 8; v++) begin
            chk("run_stim", 32'(stim), 32'(v));
            chk("run_busy", 32'(busy), 1);
            repeat (3) tick();
            chk("run_busy_late", 32'(busy), 1);
            chk("run_done_low", 32'(done), 0);
            tick();
        end
        chk("good_busy", 32'(busy), 0);
        chk("good_done", 32'(done), 1);
        chk("good_pass", 32'(pass), 1);
        chk("good_err", 32'(err_count), 0);
        chk("good_fseen", 32'(fail_seen), 0);
        chk("good_stim", 32'(stim), 0);

        // Carry stuck at 0 (started from DONE)
        fault = 1;
        start = 1'b1; tick(); start = 1'b0;
        chk("c0_cleared_done", 32'(done), 0);
        chk("c0_busy", 32'(busy), 1);
        repeat (32) tick();
        chk("c0_done", 32'(done), 1);
        chk("c0_err", 32'(err_count), 4);
        chk("c0_fvec", 32'(fail_vec), 3);
        chk("c0_pass", 32'(pass), 0);
        chk("c0_fseen", 32'(fail_seen), 1);

        // Sum inverted on vector 5 only
        fault = 2;
        start = 1'b1; tick(); start = 1'b0;
        chk("s5_err_cleared", 32'(err_count), 0);
        repeat (21) tick();
        chk("s5_stim", 32'(stim), 5);
        chk("s5_fseen_before", 32'(fail_seen), 0);
        tick();
        chk("s5_fseen_rise", 32'(fail_seen), 1);
        chk("s5_fvec_mid", 32'(fail_vec), 5);
        repeat (10) tick();
        chk("s5_done", 32'(done), 1);
        chk("s5_err", 32'(err_count), 1);
        chk("s5_fvec", 32'(fail_vec), 5);
        chk("s5_pass", 32'(pass), 0);

        // Re-pulse start mid-run is ignored
        fault = 1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (21) tick();
        chk("rp_busy31", 32'(busy), 1);
        chk("rp_done31", 32'(done), 0);
        tick();
        chk("rp_done32", 32'(done), 1);
        chk("rp_busy32", 32'(busy), 0);
        chk("rp_err", 32'(err_count), 4);
        chk("rp_fvec", 32'(fail_vec), 3);

        // Start in DONE clears results; then reset mid-run at vector 4
        start = 1'b1; tick(); start = 1'b0;
        chk("rd_done", 32'(done), 0);
        chk("rd_busy", 32'(busy), 1);
        chk("rd_err", 32'(err_count), 0);
        chk("rd_fvec", 32'(fail_vec), 0);
        chk("rd_fseen", 32'(fail_seen), 0);
        repeat (17) tick();
        chk("mr_stim4", 32'(stim), 4);
        chk("mr_err_pre", 32'(err_count), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mr_stim", 32'(stim), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_pass", 32'(pass), 0);
        chk("mr_err", 32'(err_count), 0);
        chk("mr_fvec", 32'(fail_vec), 0);
        chk("mr_fseen", 32'(fail_seen), 0);
        repeat (3) tick();
        chk("mr_idle_busy", 32'(busy), 0);

        // Start held high: one full, correct run only
        fault = 0;
        start = 1'b1; tick();
        chk("hold_busy", 32'(busy), 1);
        repeat (32) tick();
        chk("hold_done", 32'(done), 1);
        chk("hold_pass", 32'(pass), 1);
        chk("hold_err", 32'(err_count), 0);
        repeat (5) tick();
        chk("hold_no_rerun", 32'(busy), 0);
        chk("hold_done_kept", 32'(done), 1);
        start = 1'b0;

        // Coincident sample/step: SETTLE=3, carry wrong on vector 7
        start2 = 1'b1; tick(); start2 = 1'b0;
        repeat (31) tick();
        chk("co_busy31", 32'(busy2), 1);
        tick();
        chk("co_done", 32'(done2), 1);
        chk("co_err", 32'(err_count2), 1);
        chk("co_pass", 32'(pass2), 0);
        chk("co_fvec", 32'(fail_vec2), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
